// File: rtl/load_store_unit.sv
// Load/store unit between EX/MEM and a word-write, big-endian data memory.
// Sub-word stores are performed as read-modify-write of the containing word.
module load_store_unit #(
  parameter int unsigned ADDR_LIMIT = 1024,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_error,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [2:0] {IDLE, LOAD, STORE_W, RMW_READ, RMW_WRITE, RESP} state_t;

  state_t            state, next;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [DATA_W-1:0] addr_q, wdata_q, merge_q;

  logic              accept, req_err;
  logic [2:0]        nbytes;
  logic [32:0]       last_byte;
  logic [4:0]        lane_shift;
  logic [31:0]       lane_mask, merged, shifted, load_val;

  assign accept = req_valid && (state == IDLE);

  // 33-bit sum so an address near 2^32 cannot wrap past the range check
  always_comb begin
    nbytes = 3'd4;
    case (req_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    last_byte = {1'b0, req_addr} + 33'(nbytes) - 33'd1;
    req_err = (req_size == 2'b11)
           || (req_size == 2'b01 && req_addr[0])
           || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
           || (last_byte >= 33'(ADDR_LIMIT));
  end

  // Byte offset 0 lives in [31:24], so the lane shift counts down from 24
  always_comb begin
    lane_shift = (size_q == 2'b00) ? {~addr_q[1:0], 3'b000}
                                   : (addr_q[1] ? 5'd0 : 5'd16);
    lane_mask  = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_shift;
    merged     = (merge_q & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
    shifted    = mem_read_data >> lane_shift;
    case (size_q)
      2'b00:   load_val = unsigned_q ? {24'd0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = unsigned_q ? {16'd0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = mem_read_data;
    endcase
  end

  always_comb begin
    next           = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    mem_write      = 1'b0;
    mem_write_data = '0;
    mem_address    = {addr_q[DATA_W-1:2], 2'b00};
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                next = RESP;
          else if (!req_write)        next = LOAD;
          else if (req_size == 2'b10) next = STORE_W;
          else                        next = RMW_READ;
        end
      end
      LOAD:     next = RESP;
      STORE_W: begin
        mem_write      = !reset;
        mem_write_data = wdata_q;
        next           = RESP;
      end
      RMW_READ: next = RMW_WRITE;
      RMW_WRITE: begin
        mem_write      = !reset;
        mem_write_data = merged;
        next           = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next = IDLE;
      end
      default:  next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      resp_data  <= '0;
      resp_error <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        resp_data  <= '0;
        resp_error <= req_err;
      end
      if (state == LOAD)     resp_data <= load_val;
      if (state == RMW_READ) merge_q   <= mem_read_data;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a byte-array big-endian memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_data;
  logic        mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  load_store_unit #(.ADDR_LIMIT(1024), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_error(resp_error),
    .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];
  int         wcount = 0;
  logic [7:0] wa;

  assign wa = mem_address[9:2];
  assign mem_read_data = {mem[{wa, 2'b00}], mem[{wa, 2'b01}],
                          mem[{wa, 2'b10}], mem[{wa, 2'b11}]};

  always @(posedge clk) begin
    if (mem_write) begin
      mem[{wa, 2'b00}] <= mem_write_data[31:24];
      mem[{wa, 2'b01}] <= mem_write_data[23:16];
      mem[{wa, 2'b10}] <= mem_write_data[15:8];
      mem[{wa, 2'b11}] <= mem_write_data[7:0];
      wcount <= wcount + 1;
    end
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          wcyc;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  // One request through the unit; hold = cycles resp_ready stays low once resp_valid rises
  task automatic run(input string tag, input bit w, input logic [1:0] sz, input bit u,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] ed, input bit ee, input int el,
                     input int ewc, input logic [31:0] ewd, input int hold);
    exp_t e, got;
    int   lat, nwr;
    bit   seen;
    e.data = ed; e.err = ee; e.lat = el; e.wcyc = ewc; e.wdata = ewd;
    @(negedge clk);
    exp_q.push_back(e);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    resp_ready = (hold == 0);
    check({tag, ":ready"}, 32'(req_ready), 32'd1);
    lat = 0; nwr = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      req_valid = 1'b0;
      if (mem_write) begin
        nwr++;
        got = exp_q[0];
        check({tag, ":wcyc"}, 32'(lat), 32'(got.wcyc));
        check({tag, ":wdata"}, mem_write_data, got.wdata);
        check({tag, ":waddr"}, mem_address, {a[31:2], 2'b00});
      end
      if (resp_valid) seen = 1'b1;
    end
    if (!seen) begin
      check({tag, ":timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
      return;
    end
    got = exp_q.pop_front();
    check({tag, ":lat"}, 32'(lat), 32'(got.lat));
    check({tag, ":data"}, resp_data, got.data);
    check({tag, ":err"}, 32'(resp_error), 32'(got.err));
    check({tag, ":nwr"}, 32'(nwr), (got.wcyc != 0) ? 32'd1 : 32'd0);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h0;
      @(negedge clk);
      check({tag, ":hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, ":hold_data"}, resp_data, got.data);
      check({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    check({tag, ":drop_valid"}, 32'(resp_valid), 32'd0);
    check({tag, ":idle_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Reset one cycle after accepting a store, while in RMW_READ (sb) or STORE_W (sw)
  task automatic reset_mid(input string tag, input logic [1:0] sz, input logic [31:0] a);
    int          w0;
    logic [31:0] word0;
    w0 = wcount;
    word0 = word_at(int'(a[9:2]) * 4);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = sz; req_unsigned = 1'b0;
    req_addr = a; req_wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check({tag, ":wr_gated"}, 32'(mem_write), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check({tag, ":ready"}, 32'(req_ready), 32'd1);
    check({tag, ":valid"}, 32'(resp_valid), 32'd0);
    @(negedge clk);
    check({tag, ":nowrite"}, 32'(wcount - w0), 32'd0);
    check({tag, ":mem"}, word_at(int'(a[9:2]) * 4), word0);
    check({tag, ":still_idle"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[16] = 8'h80; mem[17] = 8'h12; mem[18] = 8'h34; mem[19] = 8'hFF;
    for (int i = 0; i < 8; i++) mem[32 + i] = 8'(8'h11 * (i + 1));
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst:req_ready", 32'(req_ready), 32'd1);
    check("rst:resp_valid", 32'(resp_valid), 32'd0);
    check("rst:resp_data", resp_data, 32'd0);
    check("rst:resp_error", 32'(resp_error), 32'd0);
    check("rst:mem_write", 32'(mem_write), 32'd0);
    check("rst:mem_address", mem_address, 32'd0);
    check("rst:mem_wdata", mem_write_data, 32'd0);
    reset = 1'b0;

    //   tag       w  sz    u  addr        wdata         exp data      err lat wcyc wdata     hold
    run("lw10",    0, 2'b10, 0, 32'h10,  32'h0,          32'h801234FF, 0, 2, 0, 32'h0, 0);
    run("lb10",    0, 2'b00, 0, 32'h10,  32'h0,          32'hFFFFFF80, 0, 2, 0, 32'h0, 0);
    run("lbu10",   0, 2'b00, 1, 32'h10,  32'h0,          32'h00000080, 0, 2, 0, 32'h0, 0);
    run("lh10",    0, 2'b01, 0, 32'h10,  32'h0,          32'hFFFF8012, 0, 2, 0, 32'h0, 0);
    run("lhu12",   0, 2'b01, 1, 32'h12,  32'h0,          32'h000034FF, 0, 2, 0, 32'h0, 0);
    run("lb13",    0, 2'b00, 0, 32'h13,  32'h0,          32'hFFFFFFFF, 0, 2, 0, 32'h0, 0);
    run("sb13",    1, 2'b00, 0, 32'h13,  32'h000000AA,   32'h0,        0, 3, 2, 32'h801234AA, 0);
    run("lw10b",   0, 2'b10, 0, 32'h10,  32'h0,          32'h801234AA, 0, 2, 0, 32'h0, 0);
    mem[19] = 8'hFF;
    run("sh10",    1, 2'b01, 0, 32'h10,  32'h0000BEEF,   32'h0,        0, 3, 2, 32'hBEEF34FF, 0);
    run("lw10c",   0, 2'b10, 0, 32'h10,  32'h0,          32'hBEEF34FF, 0, 2, 0, 32'h0, 0);
    run("sh12",    1, 2'b01, 0, 32'h12,  32'hFFFF1234,   32'h0,        0, 3, 2, 32'hBEEF1234, 0);
    run("sw3fc",   1, 2'b10, 0, 32'h3FC, 32'hDEADBEEF,   32'h0,        0, 2, 1, 32'hDEADBEEF, 0);
    run("lw3fc",   0, 2'b10, 0, 32'h3FC, 32'h0,          32'hDEADBEEF, 0, 2, 0, 32'h0, 0);
    run("lh3fe",   0, 2'b01, 0, 32'h3FE, 32'h0,          32'hFFFFBEEF, 0, 2, 0, 32'h0, 0);
    run("lbu3ff",  0, 2'b00, 1, 32'h3FF, 32'h0,          32'h000000EF, 0, 2, 0, 32'h0, 0);
    run("e_lw12",  0, 2'b10, 0, 32'h12,  32'h0,          32'h0,        1, 1, 0, 32'h0, 0);
    run("e_lh11",  0, 2'b01, 0, 32'h11,  32'h0,          32'h0,        1, 1, 0, 32'h0, 0);
    run("e_lw400", 0, 2'b10, 0, 32'h400, 32'h0,          32'h0,        1, 1, 0, 32'h0, 0);
    run("e_sz11",  0, 2'b11, 0, 32'h10,  32'h0,          32'h0,        1, 1, 0, 32'h0, 0);
    run("e_lb400", 0, 2'b00, 0, 32'h400, 32'h0,          32'h0,        1, 1, 0, 32'h0, 0);
    run("e_sw3fe", 1, 2'b10, 0, 32'h3FE, 32'h12345678,   32'h0,        1, 1, 0, 32'h0, 0);
    run("e_sh3ff", 1, 2'b01, 0, 32'h3FF, 32'h12345678,   32'h0,        1, 1, 0, 32'h0, 0);
    run("e_wrap",  0, 2'b10, 0, 32'hFFFFFFFC, 32'h0,     32'h0,        1, 1, 0, 32'h0, 0);
    run("bp_lw10", 0, 2'b10, 0, 32'h10,  32'h0,          32'hBEEF1234, 0, 2, 0, 32'h0, 3);
    run("lw3fc_b", 0, 2'b10, 0, 32'h3FC, 32'h0,          32'hDEADBEEF, 0, 2, 0, 32'h0, 0);

    reset_mid("rst_rmw", 2'b00, 32'h21);
    reset_mid("rst_sw",  2'b10, 32'h24);
    run("lw20",    0, 2'b10, 0, 32'h20,  32'h0,          32'h11223344, 0, 2, 0, 32'h0, 0);
    run("lw24",    0, 2'b10, 0, 32'h24,  32'h0,          32'h55667788, 0, 2, 0, 32'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
